// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard control unit.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int          LAT_ALU_FWD  = 0;
  localparam int          LAT_LOAD_FWD = 1;
  localparam logic [4:0]  REG_ZERO     = 5'd0;

endpackage

// File: rtl/hazard_control_unit_scoreboard.sv
// Per-register pending-write down-counters for registers 1..31 with two lookup ports.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int WB_LAT = 3,
  localparam int CW    = $clog2(WB_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [4:0]    load_idx,
  input  logic [CW-1:0] load_val,
  input  logic [4:0]    rd_idx_a,
  input  logic [4:0]    rd_idx_b,
  output logic          pend_a,
  output logic          pend_b
);

  logic [31:0] pend_vec_s;

  assign pend_vec_s[0] = 1'b0;

  for (genvar i = 1; i < 32; i++) begin : g_cnt
    logic [CW-1:0] cnt_r;

    // A fresh load wins over the decrement of the same counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r <= {CW{1'b0}};
      end else if (load_en && (load_idx == 5'(i))) begin
        cnt_r <= load_val;
      end else if (cnt_r != {CW{1'b0}}) begin
        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign pend_vec_s[i] = |cnt_r;
  end

  assign pend_a = pend_vec_s[rd_idx_a];
  assign pend_b = pend_vec_s[rd_idx_b];

endmodule

// File: rtl/hazard_control_unit.sv
// Decode-stage hazard control: scoreboard stalls, taken-branch flush/redirect, stall counter.
// Optional macro HAZARD_FORWARD_EN selects forwarding-aware write latencies.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic             stall,
  output logic             if_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW = $clog2(WB_LAT + 1);

  state_t            state_r;
  state_t            state_next_s;
  logic              pend_rs_s;
  logic              pend_rt_s;
  logic              stall_s;
  logic              issue_s;
  logic              load_en_s;
  logic [CW-1:0]     lat_s;
  logic              if_flush_r;
  logic              redirect_valid_r;
  logic [31:0]       redirect_pc_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  reg_scoreboard #(.WB_LAT(WB_LAT)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en_s),
    .load_idx (id_rd),
    .load_val (lat_s),
    .rd_idx_a (id_rs),
    .rd_idx_b (id_rt),
    .pend_a   (pend_rs_s),
    .pend_b   (pend_rt_s)
  );

`ifdef HAZARD_FORWARD_EN
  assign lat_s = id_load ? CW'(LAT_LOAD_FWD) : CW'(LAT_ALU_FWD);
`else
  logic unused_load_s;
  assign unused_load_s = id_load;
  assign lat_s = CW'(WB_LAT);
`endif

  // Stall on a pending source; decode input is ignored while flushing.
  always_comb begin
    stall_s = 1'b0;
    if (id_valid && (state_r == RUN)) begin
      stall_s = (id_use_rs & pend_rs_s) | (id_use_rt & pend_rt_s);
    end else begin
      stall_s = 1'b0;
    end
  end

  assign issue_s   = id_valid & ~stall_s & (state_r == RUN);
  assign load_en_s = issue_s & id_wr & (id_rd != REG_ZERO);

  // Next-state logic: a taken branch that issues opens one flush cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (issue_s && br_taken) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH:   state_next_s = RUN;
      default: state_next_s = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered flush/redirect outputs and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_flush_r       <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0000_0000;
      stall_cnt_r      <= {CNT_W{1'b0}};
    end else begin
      if_flush_r       <= (state_next_s == FLUSH);
      redirect_valid_r <= (state_next_s == FLUSH);
      if ((state_r == RUN) && issue_s && br_taken) begin
        redirect_pc_r <= br_target;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign stall          = stall_s;
  assign if_flush       = if_flush_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign stall_cnt      = stall_cnt_r;

endmodule
